// File: rtl/seg7_frame_reader.sv
// Receive side of a multiplexed seven-segment display: debounces each digit,
// decodes glyphs to BCD and converts each complete frame to a binary value.
module seg7_frame_reader #(
  parameter int unsigned NUM_DIGITS     = 2,
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned VAL_W          = 7,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                    clk,
  input  logic                    master_reset,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   digit_sel,
  input  logic                    err_clr,
  output logic [4*NUM_DIGITS-1:0] digits_bcd,
  output logic [VAL_W-1:0]        value,
  output logic                    value_valid,
  output logic                    err_glyph,
  output logic                    err_sel
);

  localparam int unsigned SAMP_W = NUM_DIGITS + 7;
  localparam int unsigned CNT_W  = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned BCD_W  = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {
    S_COLLECT,
    S_CONVERT,
    S_PUBLISH
  } state_e;

  state_e            state_q, state_d;
  logic [SAMP_W-1:0] samp_q, samp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0] seen_q, seen_d;
  logic [BCD_W-1:0]  slots_q, slots_d;
  logic [BCD_W-1:0]  snap_q, snap_d;
  logic [VAL_W-1:0]  acc_q, acc_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [VAL_W-1:0]  value_q, value_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic              vv_q, vv_d;
  logic              eg_q, eg_d;
  logic              es_q, es_d;

  logic [SAMP_W-1:0]     cur_c;
  logic                  same_c;
  logic                  accept_c;
  logic                  multi_c;
  logic [6:0]            seg_eff_c;
  logic [4:0]            glyph_c;
  logic [NUM_DIGITS-1:0] new_seen_c;
  logic [NUM_DIGITS-1:0] seen_base_c;
  logic [3:0]            digit_c;

  // Returns {legal, bcd} for an active-high segment pattern; blank reads as 0.
  function automatic logic [4:0] decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h3F, 7'h00: r = {1'b1, 4'd0};
      7'h06:        r = {1'b1, 4'd1};
      7'h5B:        r = {1'b1, 4'd2};
      7'h4F:        r = {1'b1, 4'd3};
      7'h66:        r = {1'b1, 4'd4};
      7'h6D:        r = {1'b1, 4'd5};
      7'h7D:        r = {1'b1, 4'd6};
      7'h07:        r = {1'b1, 4'd7};
      7'h7F:        r = {1'b1, 4'd8};
      7'h6F:        r = {1'b1, 4'd9};
      default:      r = {1'b0, 4'd0};
    endcase
    return r;
  endfunction

  always_comb begin
    cur_c     = {digit_sel, seg_in};
    same_c    = (cur_c == samp_q);
    seg_eff_c = SEG_ACTIVE_LOW ? ~seg_in : seg_in;
    glyph_c   = decode(seg_eff_c);
    multi_c   = |(digit_sel & (digit_sel - NUM_DIGITS'(1)));
    digit_c   = snap_q[{idx_q, 2'b00} +: 4];

    samp_d  = cur_c;
    state_d = state_q;
    seen_d  = seen_q;
    slots_d = slots_q;
    snap_d  = snap_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    value_d = value_q;
    bcd_d   = bcd_q;
    vv_d    = 1'b0;
    eg_d    = eg_q & ~err_clr;
    es_d    = es_q & ~err_clr;
    new_seen_c  = '0;
    seen_base_c = seen_q;

    // Run-length counter: fires once when a repeated sample reaches the threshold.
    if (!same_c) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q < CNT_W'(STABLE_CYCLES)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
    accept_c = (cnt_d == CNT_W'(STABLE_CYCLES)) &&
               (!same_c || (cnt_q != CNT_W'(STABLE_CYCLES)));

    if (accept_c && (|digit_sel)) begin
      if (multi_c) begin
        es_d = 1'b1;
      end else if (!glyph_c[4]) begin
        eg_d = 1'b1;
      end else begin
        new_seen_c = digit_sel;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
          if (digit_sel[i]) slots_d[4*i +: 4] = glyph_c[3:0];
        end
      end
    end

    case (state_q)
      S_COLLECT: begin
        if (&seen_q) begin
          snap_d      = slots_q;
          seen_base_c = '0;
          acc_d       = '0;
          idx_d       = IDX_W'(NUM_DIGITS - 1);
          state_d     = S_CONVERT;
        end
      end
      S_CONVERT: begin
        acc_d = acc_q * VAL_W'(10) + VAL_W'(digit_c);
        if (idx_q == '0) begin
          value_d = acc_d;
          bcd_d   = snap_q;
          vv_d    = 1'b1;
          state_d = S_PUBLISH;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      S_PUBLISH: state_d = S_COLLECT;
      default:   state_d = S_COLLECT;
    endcase

    seen_d = seen_base_c | new_seen_c;
  end

  always_ff @(posedge clk or negedge master_reset) begin
    if (!master_reset) begin
      state_q <= S_COLLECT;
      samp_q  <= '0;
      cnt_q   <= '0;
      seen_q  <= '0;
      slots_q <= '0;
      snap_q  <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      value_q <= '0;
      bcd_q   <= '0;
      vv_q    <= 1'b0;
      eg_q    <= 1'b0;
      es_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      samp_q  <= samp_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
      slots_q <= slots_d;
      snap_q  <= snap_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      value_q <= value_d;
      bcd_q   <= bcd_d;
      vv_q    <= vv_d;
      eg_q    <= eg_d;
      es_q    <= es_d;
    end
  end

  assign digits_bcd  = bcd_q;
  assign value       = value_q;
  assign value_valid = vv_q;
  assign err_glyph   = eg_q;
  assign err_sel     = es_q;

endmodule

// File: tb/tb_seg7_frame_reader.sv
// Directed bench for seg7_frame_reader: an active-high and an active-low build
// see the same logical stimulus and are both checked against one frame model.
module tb_seg7_frame_reader;

  localparam int ND = 2;
  localparam int SC = 4;

  logic       clk = 1'b0;
  logic       master_reset = 1'b0;
  logic [6:0] seg = '0;
  logic [1:0] sel = '0;
  logic       err_clr = 1'b0;

  logic [7:0] bcd_a, bcd_n;
  logic [6:0] val_a, val_n;
  logic       vv_a, vv_n, eg_a, eg_n, es_a, es_n;
  logic [6:0] seg_inv;

  int total = 0;
  int bad = 0;

  assign seg_inv = ~seg;

  always #5 clk = ~clk;

  seg7_frame_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC), .VAL_W(7), .SEG_ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .master_reset(master_reset), .seg_in(seg), .digit_sel(sel), .err_clr(err_clr),
    .digits_bcd(bcd_a), .value(val_a), .value_valid(vv_a), .err_glyph(eg_a), .err_sel(es_a));

  seg7_frame_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC), .VAL_W(7), .SEG_ACTIVE_LOW(1'b1)) dut_n (
    .clk(clk), .master_reset(master_reset), .seg_in(seg_inv), .digit_sel(sel), .err_clr(err_clr),
    .digits_bcd(bcd_n), .value(val_n), .value_valid(vv_n), .err_glyph(eg_n), .err_sel(es_n));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  // Frame model: glyph table, run lengths and a decimal sum per complete frame.
  logic [8:0] m_run_val;
  int         m_run_len;
  int         m_slot[ND];
  bit [ND-1:0] m_seen;
  int         m_pend;
  int         m_pval;
  logic [7:0] m_pbcd;
  logic       m_vv, m_eg, m_es;
  int         m_value;
  logic [7:0] m_bcd;

  function automatic int glyph_digit(input logic [6:0] s);
    logic [6:0] tbl[10];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    if (s == 7'h00) return 0;
    for (int d = 0; d < 10; d++) if (tbl[d] == s) return d;
    return -1;
  endfunction

  task automatic model_step();
    int d;
    int p;
    if ({sel, seg} == m_run_val) m_run_len++;
    else begin
      m_run_val = {sel, seg};
      m_run_len = 1;
    end
    m_vv = 1'b0;
    if (m_pend > 0) begin
      m_pend--;
      if (m_pend == 0) begin
        m_vv = 1'b1;
        m_value = m_pval;
        m_bcd = m_pbcd;
      end
    end
    if (err_clr) begin
      m_eg = 1'b0;
      m_es = 1'b0;
    end
    if (m_run_len == SC && sel != 0) begin
      if ($countones(sel) > 1) m_es = 1'b1;
      else begin
        d = glyph_digit(seg);
        if (d < 0) m_eg = 1'b1;
        else begin
          for (int i = 0; i < ND; i++) if (sel[i]) begin
            m_slot[i] = d;
            m_seen[i] = 1'b1;
          end
          if (&m_seen) begin
            m_pval = 0;
            p = 1;
            for (int i = 0; i < ND; i++) begin
              m_pval += m_slot[i] * p;
              p *= 10;
              m_pbcd[4*i +: 4] = 4'(m_slot[i]);
            end
            m_seen = '0;
            m_pend = ND + 1;
          end
        end
      end
    end
  endtask

  always @(posedge clk or negedge master_reset) begin
    if (!master_reset) begin
      m_run_val = '0; m_run_len = 0; m_seen = '0; m_pend = 0; m_pval = 0;
      m_pbcd = '0; m_vv = 1'b0; m_eg = 1'b0; m_es = 1'b0; m_value = 0; m_bcd = '0;
      for (int i = 0; i < ND; i++) m_slot[i] = 0;
    end else begin
      model_step();
    end
  end

  // Every cycle both builds must match the model.
  always @(negedge clk) begin
    chk("valid", 32'(vv_a), 32'(m_vv));
    chk("value", 32'(val_a), 32'(m_value));
    chk("bcd", 32'(bcd_a), 32'(m_bcd));
    chk("err_glyph", 32'(eg_a), 32'(m_eg));
    chk("err_sel", 32'(es_a), 32'(m_es));
    chk("valid_al", 32'(vv_n), 32'(m_vv));
    chk("value_al", 32'(val_n), 32'(m_value));
    chk("bcd_al", 32'(bcd_n), 32'(m_bcd));
    chk("err_glyph_al", 32'(eg_n), 32'(m_eg));
    chk("err_sel_al", 32'(es_n), 32'(m_es));
  end

  task automatic present(input logic [1:0] s, input logic [6:0] g, input int n);
    for (int i = 0; i < n; i++) begin
      sel = s;
      seg = g;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    sel = '0;
    seg = '0;
  endtask

  // Called right after the accept edge that completes a frame.
  task automatic expect_frame(input string tag, input logic [7:0] bcd, input int val);
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk({tag, "_early"}, 32'(vv_a), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(vv_a), 32'd1);
    chk({tag, "_value"}, 32'(val_a), 32'(val));
    chk({tag, "_bcd"}, 32'(bcd_a), 32'(bcd));
    chk({tag, "_value_al"}, 32'(val_n), 32'(val));
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(vv_a), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_value", 32'(val_a), 32'd0);
    chk("rst_bcd", 32'(bcd_a), 32'd0);
    chk("rst_valid", 32'(vv_a), 32'd0);
    @(posedge clk);
    #1 master_reset = 1'b1;
    present(2'b00, 7'h00, 2);

    // 1: digits 3 then 4
    present(2'b01, 7'h4F, 4);
    present(2'b10, 7'h66, 4);
    expect_frame("t1", 8'h43, 43);

    // 2: a three-cycle run is not accepted
    present(2'b01, 7'h06, 3);
    present(2'b01, 7'h5B, 4);
    present(2'b10, 7'h3F, 4);
    expect_frame("t2", 8'h02, 2);

    // 3: blank most significant digit
    present(2'b01, 7'h7F, 4);
    present(2'b10, 7'h00, 4);
    expect_frame("t3", 8'h08, 8);
    chk("t3_eg", 32'(eg_a), 32'd0);
    chk("t3_es", 32'(es_a), 32'd0);

    // 4: illegal glyph, frame needs a legal digit0
    present(2'b01, 7'h49, 4);
    idle();
    @(negedge clk);
    chk("t4_eg", 32'(eg_a), 32'd1);
    present(2'b10, 7'h06, 4);
    idle();
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("t4_novalid", 32'(vv_a), 32'd0);
    @(posedge clk);
    #1;
    present(2'b01, 7'h3F, 4);
    expect_frame("t4", 8'h10, 10);
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    @(negedge clk);
    chk("t4_clr", 32'(eg_a), 32'd0);

    // 5: two digits enabled, then 9 and 8
    present(2'b11, 7'h3F, 4);
    idle();
    @(negedge clk);
    chk("t5_es", 32'(es_a), 32'd1);
    @(posedge clk);
    #1;
    present(2'b01, 7'h7F, 4);
    present(2'b10, 7'h6F, 4);
    expect_frame("t5", 8'h98, 98);

    // 6: reset in the middle of conversion
    present(2'b01, 7'h06, 4);
    present(2'b10, 7'h5B, 4);
    idle();
    repeat (2) @(posedge clk);
    #1 master_reset = 1'b0;
    #1;
    chk("t6_value", 32'(val_a), 32'd0);
    chk("t6_bcd", 32'(bcd_a), 32'd0);
    chk("t6_es", 32'(es_a), 32'd0);
    @(posedge clk);
    #1 master_reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t6_nopulse", 32'(vv_a), 32'd0);
    end
    @(posedge clk);
    #1;
    present(2'b01, 7'h6D, 4);
    present(2'b10, 7'h07, 4);
    expect_frame("t6", 8'h75, 75);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
